// File: rtl/cascade_ctrl.sv
// cascade_ctrl: 8259A-style cascade controller.
// Master: drives the slave ID for the acknowledged IR line onto CAS.
// Slave: compares CAS with its own ID and decides which INTA pulses it answers.
// Tracks the INTA pulse sequence (3 pulses for 8080, 2 pulses for 8086).
// Aborts when INTA stays high for too long between pulses.
//
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   sp_en_n     - 1 = master, 0 = slave (sampled in IDLE)
//   sngl        - no cascade: CAS never driven, own vector always supplied
//   mode_8086   - 1 = 2-pulse sequence, 0 = 3-pulse sequence (sampled in IDLE)
//   slave_mask  - master ICW3; bit i set = IR i has a slave
//   slave_id    - slave ICW3 ID
//   ack_irq     - master: IR index being acknowledged, valid at the first INTA fall
//   inta_n      - INTA strobe, already synchronous to clk
//   cas_in      - CAS bus input
//   cas_out     - CAS bus drive value
//   cas_oe      - CAS output enable
//   vec_en      - this device drives the data bus in the current INTA low phase
//   vec_sel     - byte to drive: 0 = CALL, 1 = low/vector byte, 2 = high byte
//   seq_done    - one-cycle pulse on the rise of the last INTA pulse
//   seq_err     - one-cycle pulse on timeout abort
module cascade_ctrl #(
    parameter int unsigned CAS_W   = 3,
    parameter int unsigned TMO_CYC = 64,
    parameter int unsigned TMO_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sp_en_n,
    input  logic                  sngl,
    input  logic                  mode_8086,
    input  logic [2**CAS_W-1:0]   slave_mask,
    input  logic [CAS_W-1:0]      slave_id,
    input  logic [CAS_W-1:0]      ack_irq,
    input  logic                  inta_n,
    input  logic [CAS_W-1:0]      cas_in,
    output logic [CAS_W-1:0]      cas_out,
    output logic                  cas_oe,
    output logic                  vec_en,
    output logic [1:0]            vec_sel,
    output logic                  seq_done,
    output logic                  seq_err
);

    // The counter is cleared on the rise and advanced once per HIGH cycle;
    // the abort fires on the edge at which it would reach TMO_CYC-1.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH
    } state_t;

    state_t state_q, state_d;

    logic             inta_q;
    logic             fall, rise;

    logic             mode_q, mode_d;       // latched mode_8086
    logic             master_q, master_d;   // master role (sngl folds in here)
    logic             casc_q, casc_d;       // master with a slave on this IR
    logic             sel_q, sel_d;         // slave addressed on CAS
    logic [1:0]       pc_q, pc_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic [CAS_W-1:0] cas_out_d;
    logic             cas_oe_d;
    logic             vec_en_d;
    logic [1:0]       vec_sel_d;
    logic             seq_done_d;
    logic             seq_err_d;

    logic             last_pulse;
    logic             tmo_hit;
    logic             casc_new;
    logic             sel_new;
    logic [2:0]       drv_new, drv_next;

    assign fall       = inta_q & ~inta_n;
    assign rise       = ~inta_q & inta_n;
    assign last_pulse = (pc_q == (mode_q ? 2'd2 : 2'd3));
    assign tmo_hit    = (tmo_q == TMO_LAST);

    // Role decisions made from the live config at the first fall.
    assign casc_new = sp_en_n & ~sngl & slave_mask[ack_irq];
    assign sel_new  = ~sp_en_n & ~sngl & (cas_in == slave_id);

    // Data-bus drive for a given pulse: {vec_en, vec_sel}.
    function automatic logic [2:0] drive(input logic       m86,
                                         input logic       mst,
                                         input logic       casc,
                                         input logic       sel,
                                         input logic [1:0] pc);
        logic       en;
        logic [1:0] vs;
        en = 1'b0;
        vs = 2'd0;
        if (m86) begin
            if (pc == 2'd2) begin
                vs = 2'd1;
                en = mst ? ~casc : sel;
            end
        end else begin
            if (pc == 2'd1) begin
                vs = 2'd0;
                en = mst;
            end else begin
                vs = pc - 2'd1;
                en = mst ? ~casc : sel;
            end
        end
        return {en, vs};
    endfunction

    assign drv_new  = drive(mode_8086, sp_en_n | sngl, casc_new, sel_new, 2'd1);
    assign drv_next = drive(mode_q, master_q, casc_q, sel_q, pc_q + 2'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inta_q <= 1'b1;
        end else begin
            inta_q <= inta_n;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (fall) state_d = S_LOW;
            S_LOW:  if (rise) state_d = last_pulse ? S_IDLE : S_HIGH;
            S_HIGH: begin
                if (fall)         state_d = S_LOW;
                else if (tmo_hit) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        mode_d     = mode_q;
        master_d   = master_q;
        casc_d     = casc_q;
        sel_d      = sel_q;
        pc_d       = pc_q;
        tmo_d      = tmo_q;
        cas_out_d  = cas_out;
        cas_oe_d   = cas_oe;
        vec_en_d   = vec_en;
        vec_sel_d  = vec_sel;
        seq_done_d = 1'b0;
        seq_err_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (fall) begin
                    mode_d    = mode_8086;
                    // sngl forces master behaviour, so it is folded into the role.
                    master_d  = sp_en_n | sngl;
                    casc_d    = casc_new;
                    sel_d     = sel_new;
                    pc_d      = 2'd1;
                    cas_oe_d  = casc_new;
                    cas_out_d = casc_new ? ack_irq : '0;
                    vec_en_d  = drv_new[2];
                    vec_sel_d = drv_new[1:0];
                end
            end
            S_LOW: begin
                if (rise) begin
                    vec_en_d = 1'b0;
                    if (last_pulse) begin
                        seq_done_d = 1'b1;
                        cas_oe_d   = 1'b0;
                        cas_out_d  = '0;
                        sel_d      = 1'b0;
                        casc_d     = 1'b0;
                        vec_sel_d  = 2'd0;
                    end else begin
                        tmo_d = '0;
                    end
                end
            end
            S_HIGH: begin
                if (fall) begin
                    pc_d      = pc_q + 2'd1;
                    vec_en_d  = drv_next[2];
                    vec_sel_d = drv_next[1:0];
                end else if (tmo_hit) begin
                    seq_err_d = 1'b1;
                    cas_oe_d  = 1'b0;
                    cas_out_d = '0;
                    vec_en_d  = 1'b0;
                    vec_sel_d = 2'd0;
                    sel_d     = 1'b0;
                    casc_d    = 1'b0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= 1'b0;
            master_q <= 1'b0;
            casc_q   <= 1'b0;
            sel_q    <= 1'b0;
            pc_q     <= 2'd0;
            tmo_q    <= '0;
            cas_out  <= '0;
            cas_oe   <= 1'b0;
            vec_en   <= 1'b0;
            vec_sel  <= 2'd0;
            seq_done <= 1'b0;
            seq_err  <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            master_q <= master_d;
            casc_q   <= casc_d;
            sel_q    <= sel_d;
            pc_q     <= pc_d;
            tmo_q    <= tmo_d;
            cas_out  <= cas_out_d;
            cas_oe   <= cas_oe_d;
            vec_en   <= vec_en_d;
            vec_sel  <= vec_sel_d;
            seq_done <= seq_done_d;
            seq_err  <= seq_err_d;
        end
    end

endmodule

// File: tb/tb_cascade_ctrl.sv
// Scoreboard bench for cascade_ctrl (CAS_W = 3, TMO_CYC = 8).
// Stimulus pushes expected observations; the monitor pops on each DUT event:
//   PULSE - one cycle into every INTA low phase (registered drives valid)
//   DONE  - seq_done high
//   ERR   - seq_err high
//   SNAP  - requested by stimulus (reset checks)
module tb_cascade_ctrl;

    localparam int K_PULSE = 0;
    localparam int K_DONE  = 1;
    localparam int K_ERR   = 2;
    localparam int K_SNAP  = 3;

    logic       clk;
    logic       rst_n;
    logic       sp_en_n;
    logic       sngl;
    logic       mode_8086;
    logic [7:0] slave_mask;
    logic [2:0] slave_id;
    logic [2:0] ack_irq;
    logic       inta_n;
    logic [2:0] cas_in;
    logic [2:0] cas_out;
    logic       cas_oe;
    logic       vec_en;
    logic [1:0] vec_sel;
    logic       seq_done;
    logic       seq_err;

    cascade_ctrl #(
        .CAS_W  (3),
        .TMO_CYC(8),
        .TMO_W  (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sp_en_n   (sp_en_n),
        .sngl      (sngl),
        .mode_8086 (mode_8086),
        .slave_mask(slave_mask),
        .slave_id  (slave_id),
        .ack_irq   (ack_irq),
        .inta_n    (inta_n),
        .cas_in    (cas_in),
        .cas_out   (cas_out),
        .cas_oe    (cas_oe),
        .vec_en    (vec_en),
        .vec_sel   (vec_sel),
        .seq_done  (seq_done),
        .seq_err   (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int    kind;
        int    oe;
        int    out;
        int    en;
        int    vs;
        int    hi;
        string tag;
    } exp_t;

    exp_t sb[$];

    int tests = 0;
    int fails = 0;
    int low_cnt = 0;
    int hi_cnt = 0;
    int snap_req = 0;
    int snap_seen = 0;
    bit end_req = 1'b0;
    bit end_done = 1'b0;

    function automatic void push(int k, int oe, int out, int en, int vs, int hi, string tag);
        exp_t e;
        e.kind = k; e.oe = oe; e.out = out; e.en = en; e.vs = vs; e.hi = hi; e.tag = tag;
        sb.push_back(e);
    endfunction

    function automatic void push_p(int oe, int out, int en, int vs, string tag);
        push(K_PULSE, oe, out, en, vs, 0, tag);
    endfunction

    task automatic chk(string nm, int act, int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: actual %0d required %0d", nm, act, req);
        end
    endtask

    task automatic take(int k);
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: actual kind %0d required none (t=%0t)", k, $time);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".kind"}, k, e.kind);
            case (e.kind)
                K_PULSE: begin
                    chk({e.tag, ".cas_oe"}, int'(cas_oe), e.oe);
                    chk({e.tag, ".cas_out"}, int'(cas_out), e.out);
                    chk({e.tag, ".vec_en"}, int'(vec_en), e.en);
                    if (e.en != 0) chk({e.tag, ".vec_sel"}, int'(vec_sel), e.vs);
                end
                K_DONE, K_ERR: begin
                    chk({e.tag, ".delay"}, hi_cnt, e.hi);
                    chk({e.tag, ".cas_oe"}, int'(cas_oe), 0);
                    chk({e.tag, ".vec_en"}, int'(vec_en), 0);
                end
                default: begin
                    chk({e.tag, ".cas_oe"}, int'(cas_oe), e.oe);
                    chk({e.tag, ".cas_out"}, int'(cas_out), e.out);
                    chk({e.tag, ".vec_en"}, int'(vec_en), e.en);
                    chk({e.tag, ".vec_sel"}, int'(vec_sel), e.vs);
                    chk({e.tag, ".pulses"}, int'(seq_done) + 2 * int'(seq_err), 0);
                end
            endcase
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (inta_n) begin
            hi_cnt++;
            low_cnt = 0;
        end else begin
            low_cnt++;
            hi_cnt = 0;
        end
        if (snap_req != snap_seen) begin
            snap_seen = snap_req;
            take(K_SNAP);
        end else if (low_cnt == 2) begin
            take(K_PULSE);
        end
        if (seq_done) take(K_DONE);
        if (seq_err) take(K_ERR);
        if (end_req && !end_done) begin
            chk("queue_drained", sb.size(), 0);
            end_done = 1'b1;
        end
    end

    // One INTA pulse: low for 'low' cycles, then high for 'gap' cycles.
    task automatic pulse(int low, int gap);
        inta_n = 1'b0;
        repeat (low) @(posedge clk);
        #1;
        inta_n = 1'b1;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic setcfg(logic sp, logic m86, logic sg, logic [7:0] mask,
                          logic [2:0] ack, logic [2:0] id, logic [2:0] cas);
        sp_en_n    = sp;
        mode_8086  = m86;
        sngl       = sg;
        slave_mask = mask;
        ack_irq    = ack;
        slave_id   = id;
        cas_in     = cas;
    endtask

    initial begin
        rst_n = 1'b0;
        inta_n = 1'b1;
        setcfg(1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 3'd0, 3'd0);
        repeat (2) @(posedge clk);
        #1;
        push(K_SNAP, 0, 0, 0, 0, 0, "in_reset");
        snap_req++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        push(K_SNAP, 0, 0, 0, 0, 0, "after_reset");
        snap_req++;
        @(posedge clk);
        #1;

        // 8086 master, cascaded on IR2
        setcfg(1'b1, 1'b1, 1'b0, 8'h04, 3'd2, 3'd0, 3'd0);
        push_p(1, 2, 0, 0, "m86c_p1");
        push_p(1, 2, 0, 0, "m86c_p2");
        push(K_DONE, 0, 0, 0, 0, 2, "m86c_done");
        pulse(3, 2);
        pulse(3, 3);

        // 8086 master, IR5 without a slave: own vector on pulse 2
        setcfg(1'b1, 1'b1, 1'b0, 8'h00, 3'd5, 3'd0, 3'd0);
        push_p(0, 0, 0, 0, "m86o_p1");
        push_p(0, 0, 1, 1, "m86o_p2");
        push(K_DONE, 0, 0, 0, 0, 2, "m86o_done");
        pulse(3, 2);
        pulse(3, 3);

        // 8080 slave, addressed; cas_in changes after the first fall are ignored
        setcfg(1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd6, 3'd6);
        push_p(0, 0, 0, 0, "s80_p1");
        push_p(0, 0, 1, 1, "s80_p2");
        push_p(0, 0, 1, 2, "s80_p3");
        push(K_DONE, 0, 0, 0, 0, 2, "s80_done");
        pulse(3, 2);
        cas_in = 3'd1;
        pulse(3, 2);
        pulse(3, 3);

        // 8080 slave, not addressed
        setcfg(1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 3'd6, 3'd5);
        push_p(0, 0, 0, 0, "s80n_p1");
        push_p(0, 0, 0, 0, "s80n_p2");
        push_p(0, 0, 0, 0, "s80n_p3");
        push(K_DONE, 0, 0, 0, 0, 2, "s80n_done");
        pulse(3, 2);
        pulse(3, 2);
        pulse(3, 3);

        // 8080 master, single mode: CAS never driven, full own sequence
        setcfg(1'b1, 1'b0, 1'b1, 8'hFF, 3'd3, 3'd0, 3'd0);
        push_p(0, 0, 1, 0, "sg_p1");
        push_p(0, 0, 1, 1, "sg_p2");
        push_p(0, 0, 1, 2, "sg_p3");
        push(K_DONE, 0, 0, 0, 0, 2, "sg_done");
        pulse(3, 2);
        pulse(3, 2);
        pulse(3, 3);

        // Single mode overrides slave role
        setcfg(1'b0, 1'b0, 1'b1, 8'hFF, 3'd3, 3'd4, 3'd2);
        push_p(0, 0, 1, 0, "sgs_p1");
        push_p(0, 0, 1, 1, "sgs_p2");
        push_p(0, 0, 1, 2, "sgs_p3");
        push(K_DONE, 0, 0, 0, 0, 2, "sgs_done");
        pulse(3, 2);
        pulse(3, 2);
        pulse(3, 3);

        // 8080 master cascaded on IR7: master sends CALL only; mode change mid-sequence ignored
        setcfg(1'b1, 1'b0, 1'b0, 8'h80, 3'd7, 3'd0, 3'd0);
        push_p(1, 7, 1, 0, "m80c_p1");
        push_p(1, 7, 0, 0, "m80c_p2");
        push_p(1, 7, 0, 0, "m80c_p3");
        push(K_DONE, 0, 0, 0, 0, 2, "m80c_done");
        pulse(3, 2);
        mode_8086 = 1'b1;
        pulse(3, 2);
        pulse(3, 3);

        // Timeout: INTA high 10 cycles after pulse 1, then a fresh 2-pulse sequence
        setcfg(1'b1, 1'b1, 1'b0, 8'h04, 3'd2, 3'd0, 3'd0);
        push_p(1, 2, 0, 0, "tmo_p1");
        push(K_ERR, 0, 0, 0, 0, 9, "tmo_err");
        push_p(1, 2, 0, 0, "tmo_new_p1");
        push_p(1, 2, 0, 0, "tmo_new_p2");
        push(K_DONE, 0, 0, 0, 0, 2, "tmo_new_done");
        pulse(3, 10);
        pulse(3, 2);
        pulse(3, 3);

        // Fall in the terminal-count cycle wins over the abort
        push_p(1, 2, 0, 0, "term_p1");
        push_p(1, 2, 0, 0, "term_p2");
        push(K_DONE, 0, 0, 0, 0, 2, "term_done");
        pulse(3, 7);
        pulse(3, 3);

        // Reset asserted during pulse 2 of a cascaded sequence
        push_p(1, 2, 0, 0, "rst_p1");
        push_p(1, 2, 0, 0, "rst_p2");
        push(K_SNAP, 0, 0, 0, 0, 0, "rst_mid");
        pulse(3, 2);
        inta_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        snap_req++;
        @(posedge clk);
        #1;
        inta_n = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        push_p(1, 2, 0, 0, "post_rst_p1");
        push_p(1, 2, 0, 0, "post_rst_p2");
        push(K_DONE, 0, 0, 0, 0, 2, "post_rst_done");
        pulse(3, 2);
        pulse(3, 5);

        end_req = 1'b1;
        repeat (4) @(posedge clk);
        if (!end_done) begin
            $display("FAIL monitor_end: actual 0 required 1");
            $fatal(1, "monitor did not finish");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cascade_ctrl.md
Name: cascade_ctrl

Overview:
- Parametrised 8259A-style cascade controller: generalises the CAS-bus comparator to configurable ID width, an INTA-sequence state machine, 8080/8086 modes, single mode and an abort timeout.
- In master mode it drives the slave ID on CAS for the acknowledged IR line.
- In slave mode it compares CAS against its own ID and decides which INTA pulses it answers.
- Sits between the priority resolver / ICW registers and the data-bus driver of the PIC.

Parameters:
- CAS_W, 3, width of CAS bus and slave ID; NSLV = 2**CAS_W IR inputs.
- TMO_CYC, 64, clk cycles allowed between INTA pulses before abort; range 2..65535.
- TMO_W, 16, width of the timeout counter; must hold TMO_CYC.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sp_en_n  in  1  1 = master, 0 = slave; sampled only in IDLE
- sngl  in  1  ICW1 SNGL; 1 = no cascade, CAS never driven, always own vector
- mode_8086  in  1  1 = 2-pulse 8086 sequence, 0 = 3-pulse 8080 sequence; sampled only in IDLE
- slave_mask  in  2**CAS_W  master ICW3; bit i = IR i has a slave
- slave_id  in  CAS_W  slave ICW3 ID
- ack_irq  in  CAS_W  master: IR index being acknowledged, valid at first INTA edge
- inta_n  in  1  INTA strobe, already synchronised to clk
- cas_in  in  CAS_W  CAS bus input
- cas_out  out  CAS_W  CAS bus drive value
- cas_oe  out  1  CAS output enable
- vec_en  out  1  this device drives the data bus during the current INTA low phase
- vec_sel  out  2  which byte to drive: 0 = CALL opcode, 1 = low/vector byte, 2 = high byte
- seq_done  out  1  one-cycle pulse on the rising edge of the last INTA pulse
- seq_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Edge detection
  - inta_n registered once; fall = prev 1 and now 0; rise = prev 0 and now 1.
  - Register reset value 1.
- Reset (async)
  - FSM = IDLE; cas_out = 0; cas_oe = 0; vec_en = 0; vec_sel = 0; seq_done = 0; seq_err = 0; timeout counter = 0.
  - Latched mode, master/slave, select and pulse-count registers = 0.
  - Reset mid-sequence drops CAS and the data drive in the same instant; no pulse is emitted.
- FSM states
  - IDLE, LOW, HIGH. Pulse counter pc counts 1..N, where N = 2 (8086) or 3 (8080).
- IDLE
  - On fall: latch sp_en_n, mode_8086 and sngl; set pc = 1; go to LOW.
  - Master and !sngl and slave_mask[ack_irq]=1: cascaded = 1, cas_out = ack_irq, cas_oe = 1 from the next cycle.
  - Slave: sel = (cas_in == slave_id), sampled on the fall cycle.
- LOW (INTA low)
  - vec_en and vec_sel are registered, valid the cycle after fall, and held until rise.
  - 8080, pc = 1: master drives CALL (vec_sel = 0). Slave never drives.
  - 8080, pc = 2 or 3: vec_sel = pc-1. Driven by the master if not cascaded; by the slave if sel.
  - 8086, pc = 1: nobody drives.
  - 8086, pc = 2: vec_sel = 1. Driven by the master if not cascaded; by the slave if sel.
  - sngl = 1 forces master behaviour with cascaded = 0, regardless of sp_en_n.
  - On rise: vec_en = 0.
    - If pc == N: pulse seq_done, clear cas_oe, cas_out = 0, sel = 0, go to IDLE.
    - Otherwise go to HIGH and clear the timeout counter.
- HIGH
  - Timeout counter increments each cycle.
  - On fall: pc = pc+1, go to LOW.
  - Counter reaching TMO_CYC-1 without a fall: pulse seq_err, clear all drives, go to IDLE.
  - A fall in the same cycle as the terminal count wins (no abort).
- LOW has no timeout; INTA width is bounded by the CPU.
- Config inputs are ignored outside IDLE, so a mid-sequence ICW write takes effect on the next sequence.
- cas_in changes after the first-fall sample are ignored.
- ack_irq outside slave_mask while master and !sngl: cascaded = 0 and the master supplies its own vector.

Test Plan:
- 8086 master, slave_mask = 8'h04, ack_irq = 2, two INTA pulses -> cas_oe = 1 and cas_out = 3'd2 from fall1+1 until rise2; vec_en = 0 throughout; seq_done pulses on rise2.
- 8086 master, slave_mask = 0, ack_irq = 5 -> cas_oe stays 0; vec_en = 1 with vec_sel = 1 during pulse 2 only; seq_done on rise2.
- 8080 slave, slave_id = 3'd6, cas_in = 6 at fall1, three pulses -> vec_en = 0 in pulse 1; vec_sel = 1 in pulse 2; vec_sel = 2 in pulse 3. Repeat with cas_in = 5 -> vec_en never 1.
- 8080 master, sngl = 1, slave_mask = 8'hFF -> cas_oe = 0; vec_sel 0, 1, 2 on pulses 1, 2, 3.
- TMO_CYC = 8, 8086 master cascaded, INTA held high 10 cycles after pulse 1 -> seq_err pulses 7 cycles after rise1; cas_oe clears the same cycle; a later fall starts a new sequence with pc = 1.
- Assert rst_n = 0 during pulse 2 of a cascaded master sequence -> cas_oe, vec_en and cas_out go to 0 immediately; no seq_done; FSM in IDLE after release.
